// File: rtl/enet_nios_ext_bus_master.sv
// enet_nios_ext_bus_master
//   Turns single Avalon-style slave transfers into timed cycles on the
//   Ethernet controller's asynchronous 16-bit host bus. Each cycle has
//   SETUP, STROBE and HOLD phases timed by a loadable down-counter. A
//   synchronized ready input can stretch the strobe, up to TIMEOUT_CYC
//   extra clocks, after which a sticky timeout flag is raised.
// Ports
//   clk, aclr (async, active high), sclr (sync clear / abort)
//   av_*  : Nios-side slave (chipselect/read/write/address/writedata in,
//           readdata/waitrequest/timeout out)
//   ext_* : external bus (cs_n/rd_n/wr_n/addr/data_out/data_oe out,
//           data_in/rdy in)
module enet_nios_ext_bus_master #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 16,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 3,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              sclr,
  input  logic              av_chipselect,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [ADDR_W-1:0] av_address,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic              av_timeout,
  output logic              ext_cs_n,
  output logic              ext_rd_n,
  output logic              ext_wr_n,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_data_out,
  output logic              ext_data_oe,
  input  logic [DATA_W-1:0] ext_data_in,
  input  logic              ext_rdy
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [9:0] TO_LIM    = 10'(TIMEOUT_CYC);

  state_t              state_q;
  logic [7:0]          cnt_q;
  logic [9:0]          ext_q;     // strobe extension clocks while rdy_s low
  logic                rdy_m_q, rdy_s_q;
  logic                is_rd_q;
  logic                cs_n_q, rd_n_q, wr_n_q, oe_q, to_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   dout_q, rdata_q;
  logic                req;

  assign req            = av_chipselect & (av_read | av_write);
  assign av_waitrequest = req & (state_q != S_DONE);
  assign av_readdata    = rdata_q;
  assign av_timeout     = to_q;
  assign ext_cs_n       = cs_n_q;
  assign ext_rd_n       = rd_n_q;
  assign ext_wr_n       = wr_n_q;
  assign ext_addr       = addr_q;
  assign ext_data_out   = dout_q;
  assign ext_data_oe    = oe_q;

  // Bus outputs are registered and updated together with the state they
  // belong to, so they change on the same edge the phase is entered.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ext_q   <= '0;
      rdy_m_q <= 1'b0;
      rdy_s_q <= 1'b0;
      is_rd_q <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      to_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else if (sclr) begin
      // Abort: the transfer in flight is abandoned, not completed.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ext_q   <= '0;
      rdy_m_q <= 1'b0;
      rdy_s_q <= 1'b0;
      is_rd_q <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      to_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      rdy_m_q <= ext_rdy;
      rdy_s_q <= rdy_m_q;
      case (state_q)
        S_IDLE: if (req) begin
          addr_q  <= av_address;
          dout_q  <= av_writedata;
          is_rd_q <= av_read;           // read wins if both are set
          cnt_q   <= SETUP_LD;
          cs_n_q  <= 1'b0;
          oe_q    <= ~av_read;
          state_q <= S_SETUP;
        end
        S_SETUP: if (cnt_q == 8'd0) begin
          cnt_q   <= STROBE_LD;
          ext_q   <= '0;
          rd_n_q  <= ~is_rd_q;
          wr_n_q  <= is_rd_q;
          state_q <= S_STROBE;
        end else begin
          cnt_q <= cnt_q - 8'd1;
        end
        S_STROBE: if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else if (rdy_s_q) begin
          // Ready has priority over the timeout on the same clock.
          if (is_rd_q) rdata_q <= ext_data_in;
          cnt_q   <= HOLD_LD;
          rd_n_q  <= 1'b1;
          wr_n_q  <= 1'b1;
          state_q <= S_HOLD;
        end else if (ext_q == TO_LIM) begin
          to_q    <= 1'b1;
          if (is_rd_q) rdata_q <= '1;
          cnt_q   <= HOLD_LD;
          rd_n_q  <= 1'b1;
          wr_n_q  <= 1'b1;
          state_q <= S_HOLD;
        end else begin
          ext_q <= ext_q + 10'd1;
        end
        S_HOLD: if (cnt_q == 8'd0) begin
          cs_n_q  <= 1'b1;
          oe_q    <= 1'b0;
          state_q <= S_DONE;
        end else begin
          cnt_q <= cnt_q - 8'd1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enet_nios_ext_bus_master.sv
module tb_enet_nios_ext_bus_master;
  logic        clk = 1'b0;
  logic        aclr, sclr;
  logic        av_chipselect, av_read, av_write;
  logic [3:0]  av_address;
  logic [15:0] av_writedata, av_readdata;
  logic        av_waitrequest, av_timeout;
  logic        ext_cs_n, ext_rd_n, ext_wr_n, ext_data_oe, ext_rdy;
  logic [3:0]  ext_addr;
  logic [15:0] ext_data_out, ext_data_in;

  int n_vec = 0, n_miss = 0;

  // per-cycle traces of one run (bit k = cycle k)
  logic [31:0] tr_cs, tr_rd, tr_wr, tr_oe, tr_wq;
  logic [15:0] done_rd [2];
  int          done_at [2];
  logic [3:0]  done_addr;
  logic [15:0] done_wd;
  int          n_done;

  always #5 clk = ~clk;

  enet_nios_ext_bus_master #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .aclr(aclr), .sclr(sclr),
    .av_chipselect(av_chipselect), .av_read(av_read), .av_write(av_write),
    .av_address(av_address), .av_writedata(av_writedata),
    .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .av_timeout(av_timeout),
    .ext_cs_n(ext_cs_n), .ext_rd_n(ext_rd_n), .ext_wr_n(ext_wr_n),
    .ext_addr(ext_addr), .ext_data_out(ext_data_out),
    .ext_data_oe(ext_data_oe), .ext_data_in(ext_data_in), .ext_rdy(ext_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One transfer window; cycle 0 is the cycle the request appears.
  // ready is low for cycles [rdy_lo, rdy_hi); sclr is high in cycle sclr_at.
  task automatic run(input bit rd, input logic [3:0] a, input logic [15:0] d,
                     input logic [15:0] din, input logic [15:0] din2,
                     input int ncyc, input int ndone,
                     input int rdy_lo, input int rdy_hi, input int sclr_at);
    int nd;
    nd = 0;
    tr_cs = '0; tr_rd = '0; tr_wr = '0; tr_oe = '0; tr_wq = '0;
    done_at[0] = -1; done_at[1] = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (k == 0) begin
        av_chipselect = 1'b1; av_read = rd; av_write = !rd;
        av_address = a; av_writedata = d; ext_data_in = din;
      end
      if (k == 7) ext_data_in = din2;
      ext_rdy = !(k >= rdy_lo && k < rdy_hi);
      sclr    = (k == sclr_at);
      #1;
      tr_cs[k] = !ext_cs_n;
      tr_rd[k] = !ext_rd_n;
      tr_wr[k] = !ext_wr_n;
      tr_oe[k] = ext_data_oe;
      tr_wq[k] = av_waitrequest;
      if (av_chipselect && !av_waitrequest && nd < 2) begin
        done_rd[nd] = av_readdata;
        done_at[nd] = k;
        done_addr   = ext_addr;
        done_wd     = ext_data_out;
        nd++;
        if (nd == ndone) begin
          av_chipselect = 1'b0; av_read = 1'b0; av_write = 1'b0;
        end
      end
      tick();
    end
    av_chipselect = 1'b0; av_read = 1'b0; av_write = 1'b0;
    sclr = 1'b0; ext_rdy = 1'b1;
    n_done = nd;
  endtask

  initial begin
    aclr = 1'b1; sclr = 1'b0;
    av_chipselect = 1'b0; av_read = 1'b0; av_write = 1'b0;
    av_address = '0; av_writedata = '0; ext_data_in = '0; ext_rdy = 1'b1;
    #3;
    chk("rst_cs_n", ext_cs_n, 1);
    chk("rst_rd_n", ext_rd_n, 1);
    chk("rst_wr_n", ext_wr_n, 1);
    chk("rst_oe", ext_data_oe, 0);
    chk("rst_addr", ext_addr, 0);
    chk("rst_dout", ext_data_out, 0);
    chk("rst_rdata", av_readdata, 0);
    chk("rst_to", av_timeout, 0);
    chk("rst_wq", av_waitrequest, 0);
    @(negedge clk); aclr = 1'b0;
    repeat (3) tick();

    // write 0xA55A to 0x3
    run(0, 4'h3, 16'hA55A, 16'h0, 16'h0, 10, 1, 99, 99, -1);
    chk("wr_cs", tr_cs, 32'h3E);
    chk("wr_wr", tr_wr, 32'h1C);
    chk("wr_rd", tr_rd, 32'h0);
    chk("wr_oe", tr_oe, 32'h3E);
    chk("wr_wq", tr_wq, 32'h3F);
    chk("wr_done", done_at[0], 6);
    chk("wr_dout", done_wd, 16'hA55A);
    chk("wr_addr", done_addr, 4'h3);
    repeat (2) tick();

    // read 0x1234
    run(1, 4'h7, 16'h0, 16'h1234, 16'h1234, 10, 1, 99, 99, -1);
    chk("rd_cs", tr_cs, 32'h3E);
    chk("rd_rd", tr_rd, 32'h1C);
    chk("rd_wr", tr_wr, 32'h0);
    chk("rd_oe", tr_oe, 32'h0);
    chk("rd_wq", tr_wq, 32'h3F);
    chk("rd_done", done_at[0], 6);
    chk("rd_data", done_rd[0], 16'h1234);
    repeat (2) tick();

    // ready low cycles 1..9: ready and the extension limit coincide in cycle 12
    run(1, 4'h1, 16'h0, 16'h5A5A, 16'h5A5A, 17, 1, 1, 10, -1);
    chk("ext_rd", tr_rd, 32'h1FFC);
    chk("ext_cs", tr_cs, 32'h3FFE);
    chk("ext_done", done_at[0], 14);
    chk("ext_data", done_rd[0], 16'h5A5A);
    chk("ext_to", av_timeout, 0);
    repeat (2) tick();

    // ready stuck low -> timeout after 3 + 8 strobe clocks
    run(1, 4'h2, 16'h0, 16'h1357, 16'h1357, 17, 1, 0, 99, -1);
    chk("to_rd", tr_rd, 32'h1FFC);
    chk("to_done", done_at[0], 14);
    chk("to_data", done_rd[0], 16'hFFFF);
    chk("to_flag", av_timeout, 1);
    repeat (3) tick();
    run(1, 4'h2, 16'h0, 16'h0BEE, 16'h0BEE, 10, 1, 99, 99, -1);
    chk("to_next_done", done_at[0], 6);
    chk("to_next_data", done_rd[0], 16'h0BEE);
    chk("to_sticky", av_timeout, 1);
    sclr = 1'b1; tick(); sclr = 1'b0;
    chk("sclr_to", av_timeout, 0);
    chk("sclr_rdata", av_readdata, 0);
    repeat (3) tick();

    // back-to-back reads with the request held
    run(1, 4'h5, 16'h0, 16'h1111, 16'h2222, 16, 2, 99, 99, -1);
    chk("b2b_cs", tr_cs, 32'h1F3E);
    chk("b2b_rd", tr_rd, 32'hE1C);
    chk("b2b_wq", tr_wq, 32'h1FBF);
    chk("b2b_n", n_done, 2);
    chk("b2b_at0", done_at[0], 6);
    chk("b2b_at1", done_at[1], 13);
    chk("b2b_d0", done_rd[0], 16'h1111);
    chk("b2b_d1", done_rd[1], 16'h2222);
    repeat (2) tick();

    // sclr during STROBE, master keeps requesting
    run(1, 4'h9, 16'h0, 16'h4321, 16'h4321, 12, 1, 99, 99, 3);
    chk("ab_cs", tr_cs, 32'h3EE);
    chk("ab_rd", tr_rd, 32'h1CC);
    chk("ab_wq", tr_wq, 32'h3FF);
    chk("ab_done", done_at[0], 10);
    chk("ab_data", done_rd[0], 16'h4321);
    repeat (2) tick();

    // aclr during SETUP acts without a clock edge
    av_chipselect = 1'b1; av_write = 1'b1; av_address = 4'hF; av_writedata = 16'hBEEF;
    tick();
    chk("ac_pre_cs", ext_cs_n, 0);
    chk("ac_pre_oe", ext_data_oe, 1);
    #2 aclr = 1'b1;
    #1;
    chk("ac_cs", ext_cs_n, 1);
    chk("ac_wr", ext_wr_n, 1);
    chk("ac_oe", ext_data_oe, 0);
    chk("ac_addr", ext_addr, 0);
    chk("ac_dout", ext_data_out, 0);
    chk("ac_rdata", av_readdata, 0);
    chk("ac_wq", av_waitrequest, 1);
    av_chipselect = 1'b0; av_write = 1'b0;
    #1 aclr = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/enet_nios_ext_bus_master.md
Name: enet_nios_ext_bus_master

Overview:
- Initiator for the external Ethernet controller's asynchronous 16-bit host bus.
- Converts single Avalon-style slave transfers from the Nios system bus into timed external cycles with chip select, read/write strobes, setup, strobe and hold phases.
- Each phase is timed by a loadable down-counter with sync load/clear. A ready input can extend the strobe, bounded by a timeout.

Parameters:
- ADDR_W, 4, external address width.
- DATA_W, 16, data width.
- SETUP_CYC, 1, clocks of address/CS before strobe (legal range 1..255).
- STROBE_CYC, 3, minimum strobe-low clocks (legal range 1..255).
- HOLD_CYC, 1, clocks of CS/address/data after strobe (legal range 1..255).
- TIMEOUT_CYC, 64, maximum extra strobe clocks while ready is low (legal range 1..1023).

Ports:
- clk  in  1  system clock.
- aclr  in  1  asynchronous active-high reset.
- sclr  in  1  synchronous clear/abort.
- av_chipselect  in  1  transfer select.
- av_read  in  1  read request.
- av_write  in  1  write request.
- av_address  in  ADDR_W  word address.
- av_writedata  in  DATA_W  write data.
- av_readdata  out  DATA_W  read data, registered.
- av_waitrequest  out  1  stall to master.
- av_timeout  out  1  sticky timeout flag.
- ext_cs_n  out  1  chip select, active low.
- ext_rd_n  out  1  read strobe, active low.
- ext_wr_n  out  1  write strobe, active low.
- ext_addr  out  ADDR_W  latched address.
- ext_data_out  out  DATA_W  latched write data.
- ext_data_oe  out  1  data bus output enable.
- ext_data_in  in  DATA_W  data from device.
- ext_rdy  in  1  asynchronous device ready, high = ready.

Behaviour:
- Reset (aclr async, or sclr sync):
  - state IDLE.
  - cs_n = rd_n = wr_n = 1, oe = 0.
  - ext_addr = 0, ext_data_out = 0, av_readdata = 0, av_timeout = 0.
  - counter = 0, rdy synchronizer cleared to 0.
- ext_rdy passes through a 2-flop synchronizer (rdy_s) before use.
- req = av_chipselect & (av_read | av_write). If read and write are both high, read wins.
- av_waitrequest = req & (state != DONE). It is combinational from state and inputs.
- IDLE:
  - If req: latch address, writedata and direction; load counter with SETUP_CYC-1; go to SETUP.
  - cs_n goes low on entry to SETUP.
- SETUP:
  - cs_n low, strobes high.
  - ext_data_oe high for writes from SETUP entry.
  - When counter = 0: load STROBE_CYC-1, go to STROBE. Otherwise decrement.
- STROBE:
  - rd_n or wr_n low per direction.
  - While counter > 0: decrement.
  - At counter = 0 with rdy_s = 1: capture ext_data_in into av_readdata (reads only); load HOLD_CYC-1; go to HOLD.
  - At counter = 0 with rdy_s = 0: hold state and increment the separate extension counter.
  - If the extension count reaches TIMEOUT_CYC: set av_timeout, force av_readdata to all ones (reads only), go to HOLD.
- HOLD:
  - Strobes high; cs_n low; oe still high for writes.
  - When counter = 0: go to DONE.
- DONE:
  - One clock; cs_n high, oe low, av_waitrequest low.
  - Next state IDLE unconditionally.
  - There are at least 2 cs_n-high clocks between external cycles.
- Latency with defaults, rdy high, request at cycle 0:
  - cs_n low cycles 1-5.
  - rd_n low cycles 2-4.
  - readdata valid and waitrequest low at cycle 6.
- Request dropped mid-cycle: the external cycle still completes. DONE then has no effect on the master.
- av_timeout stays set across later transfers. Only aclr or sclr clears it.
- sclr mid-cycle: strobes and cs_n deassert on the next clock; the transfer is abandoned; a held master re-requests from IDLE.
- The extension counter clears on STROBE entry.

Test Plan:
- Write: addr 0x3, data 0xA55A, defaults, rdy = 1 -> cs_n low 5 clocks, wr_n low 3 clocks, ext_data_out = 0xA55A with oe high for SETUP through HOLD, waitrequest low exactly at cycle 6.
- Read: ext_data_in = 0x1234 -> av_readdata = 0x1234 at cycle 6; rd_n low cycles 2-4; oe never high.
- Ready extension: rdy low from cycle 1, high at cycle 10 -> strobe stays low until 2-clock sync latency elapses, capture on the first rdy_s = 1 clock, av_timeout = 0.
- Timeout: rdy stuck low, TIMEOUT_CYC = 8 -> strobe low 3 + 8 clocks, av_timeout = 1, readdata = 0xFFFF; next good transfer completes with av_timeout still 1 until sclr.
- Back-to-back reads held asserted -> two external cycles separated by exactly 2 cs_n-high clocks; waitrequest low for one clock each.
- Abort/reset: sclr pulse in STROBE -> cs_n and rd_n high the next clock, state IDLE; aclr asserted mid-SETUP -> all outputs at reset values immediately, without a clock edge.
